// File: rtl/spi_pkg.sv
// Shared constants, frame field positions and state encoding for the
// tracking-motor SPI master.
package spi_pkg;

  localparam int FRAME_BITS = 32;

  // Motor command frame on mosi
  localparam int MOTOR_X_MSB   = 31;
  localparam int MOTOR_X_LSB   = 24;
  localparam int MOTOR_Y_MSB   = 23;
  localparam int MOTOR_Y_LSB   = 17;
  localparam int MOTOR_ETC_MSB = 16;
  localparam int MOTOR_ETC_LSB = 0;

  // Enemy-position frame on miso
  localparam int ENEMY_X_MSB   = 31;
  localparam int ENEMY_X_LSB   = 22;
  localparam int ENEMY_Y_MSB   = 21;
  localparam int ENEMY_Y_LSB   = 13;
  localparam int ENEMY_ETC_MSB = 12;
  localparam int ENEMY_ETC_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: CLK_DIV-cycle half periods, one-cycle rise/fall
// strobes marking the clk edge on which the registered sclk toggles.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);

  logic [7:0] half_cnt;
  logic       half_tc;

  assign half_tc   = en && (half_cnt == 8'd0);
  assign rise_tick = half_tc && !sclk;
  assign fall_tick = half_tc && sclk;

  // Reset leaves the counter at 0; the master spends at least one idle
  // cycle after reset, which reloads it before the first enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      half_cnt <= 8'd0;
      sclk     <= 1'b0;
    end else if (!en) begin
      half_cnt <= HALF_LOAD;
      sclk     <= 1'b0;
    end else if (half_tc) begin
      half_cnt <= HALF_LOAD;
      sclk     <= !sclk;
    end else begin
      half_cnt <= half_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first, 32-bit full-duplex SPI master for the tracking-motor link.
// Define SPI_MASTER_GAP_EN to enforce GAP_CYCLES of cs-high after every frame.
//
// state | meaning
// IDLE  | cs high, waiting for start
// SETUP | cs low, first mosi bit presented for one half period
// XFER  | 32 sclk pulses, sample miso on rise, shift mosi on fall
// HOLD  | cs low for one half period after the last falling edge
// GAP   | cs high for GAP_CYCLES, still busy
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam logic [7:0] HOLD_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS);

  state_t                state, state_next;
  logic                  sclk_en, rise_tick, fall_tick;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr;
  logic [5:0]            bit_cnt;
  logic [7:0]            wait_cnt;
  logic                  wait_tc;

  assign wait_tc = (wait_cnt == 8'd0);
  assign mosi    = tx_sr[FRAME_BITS-1];

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (sclk_en),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SETUP;
      SETUP: if (rise_tick) state_next = XFER;
      XFER:  if (fall_tick && (bit_cnt == LAST_BIT)) state_next = HOLD;
      HOLD: begin
        if (wait_tc) begin
`ifdef SPI_MASTER_GAP_EN
          state_next = GAP;
`else
          state_next = IDLE;
`endif
        end
      end
      GAP:   if (wait_tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cs      = 1'b1;
    busy    = 1'b0;
    sclk_en = 1'b0;
    case (state)
      SETUP, XFER: begin
        cs      = 1'b0;
        busy    = 1'b1;
        sclk_en = 1'b1;
      end
      HOLD: begin
        cs   = 1'b0;
        busy = 1'b1;
      end
      GAP:     busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      bit_cnt  <= 6'd0;
      wait_cnt <= 8'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && start) begin
        tx_sr   <= tx_data;
        bit_cnt <= 6'd0;
      end
      if (rise_tick) begin
        rx_sr   <= {rx_sr[FRAME_BITS-2:0], miso};
        bit_cnt <= bit_cnt + 6'd1;
      end
      // The final falling edge leaves mosi on the last bit.
      if (fall_tick && (bit_cnt != LAST_BIT))
        tx_sr <= tx_sr << 1;
      if ((state_next != state) && ((state_next == HOLD) || (state_next == GAP)))
        wait_cnt <= (state_next == GAP) ? GAP_LOAD : HOLD_LOAD;
      else if (!wait_tc)
        wait_cnt <= wait_cnt - 8'd1;
      if ((state == HOLD) && wait_tc) begin
        rx_data <= rx_sr;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (CLK_DIV 4 and 8) checked
// against frame-level timing arithmetic and a bit-level slave model.
module tb_spi_master;

  localparam int DA  = 4;
  localparam int DB  = 8;
  localparam int GAP = 8;
`ifdef SPI_MASTER_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, start_a, busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
  logic [31:0] tx_a, rx_a;
  logic        reset_b, start_b, busy_b, done_b, sclk_b, mosi_b, miso_b, cs_b;
  logic [31:0] tx_b, rx_b;

  int n_vec = 0;
  int n_err = 0;

  spi_master #(.CLK_DIV(DA), .GAP_CYCLES(GAP)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .tx_data(tx_a), .busy(busy_a),
    .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs(cs_a));

  spi_master #(.CLK_DIV(DB), .GAP_CYCLES(GAP)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .tx_data(tx_b), .busy(busy_b),
    .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs(cs_b));

  // Drives one frame on dut_a and collects what the pins did. The slave model
  // presents bit k of slave during the cycle ending at rising edge k, which by
  // the timing rules is cycle (2k+1)*DA after the accept cycle.
  task automatic run_frame_a(input logic [31:0] tx, input logic [31:0] slave,
                             input bit glitch, input int inject_at,
                             output logic [31:0] mosi_word, output int rises,
                             output int done_at, output int done_cnt,
                             output logic [31:0] rx_done, output int cs_bad,
                             output logic busy_first, output logic busy_done);
    logic prev_sclk;
    int   win;
    win = 65*DA + GAP + 6;
    mosi_word = '0; rises = 0; done_at = -1; done_cnt = 0; rx_done = '0;
    cs_bad = 0; busy_first = 1'b0; busy_done = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    tx_a    = tx;
    @(negedge clk);
    start_a   = 1'b0;
    tx_a      = $urandom;
    prev_sclk = 1'b0;
    for (int n = 1; n <= win; n++) begin
      if (n > 1) @(negedge clk);
      if (sclk_a && !prev_sclk) begin
        mosi_word = {mosi_word[30:0], mosi_a};
        rises++;
      end
      prev_sclk = sclk_a;
      if (n == 1) busy_first = busy_a;
      if (done_a) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at   = n;
          rx_done   = rx_a;
          busy_done = busy_a;
        end
      end
      if (n <= 65*DA && cs_a !== 1'b0) cs_bad++;
      if (n == 65*DA + 1 && cs_a !== 1'b1) cs_bad++;
      if ((n % (2*DA)) == DA && n <= 64*DA)
        miso_a = slave[31 - (n - DA)/(2*DA)];
      else if (glitch)
        miso_a = 1'($urandom);
      start_a = (n == inject_at);
      if (n == inject_at) tx_a = 32'hFFFF_FFFF;
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_a = 1'b0; reset_b = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({cs_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin
      n_err++; $display("FAIL reset_pins_a: got %b want 10000", {cs_a, sclk_a, mosi_a, busy_a, done_a}); end
    n_vec++; if (rx_a !== 32'h0) begin
      n_err++; $display("FAIL reset_rx_a: got %h want 00000000", rx_a); end
    n_vec++; if ({cs_b, sclk_b, mosi_b, busy_b, done_b} !== 5'b10000) begin
      n_err++; $display("FAIL reset_pins_b: got %b want 10000", {cs_b, sclk_b, mosi_b, busy_b, done_b}); end
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if ({cs_a, busy_a, rx_a} !== {2'b10, 32'h0}) begin
      n_err++; $display("FAIL reset_release_a: got cs=%b busy=%b rx=%h want cs=1 busy=0 rx=0", cs_a, busy_a, rx_a); end
  endtask

  task automatic test_single_frame();
    logic [31:0] mw, rxd;
    int rises, dat, dcnt, csb;
    logic bf, bd;
    run_frame_a(32'hA5C3_0F01, 32'h1234_5678, 1'b0, -1, mw, rises, dat, dcnt, rxd, csb, bf, bd);
    n_vec++; if (mw !== 32'hA5C3_0F01) begin n_err++; $display("FAIL single_mosi: got %h want a5c30f01", mw); end
    n_vec++; if (rxd !== 32'h1234_5678) begin n_err++; $display("FAIL single_rx: got %h want 12345678", rxd); end
    n_vec++; if (dat !== 65*DA + 1) begin n_err++; $display("FAIL single_done_time: got T0+%0d want T0+%0d", dat, 65*DA + 1); end
    n_vec++; if (rises !== 32) begin n_err++; $display("FAIL single_rises: got %0d want 32", rises); end
    n_vec++; if (dcnt !== 1) begin n_err++; $display("FAIL single_done_count: got %0d want 1", dcnt); end
    n_vec++; if (csb !== 0) begin n_err++; $display("FAIL single_cs_window: got %0d bad cycles want 0", csb); end
    n_vec++; if (bf !== 1'b1) begin n_err++; $display("FAIL single_busy_rise: got %b want 1", bf); end
    n_vec++; if (bd !== GAP_ON) begin n_err++; $display("FAIL single_busy_at_done: got %b want %b", bd, GAP_ON); end
  endtask

  task automatic test_reset_mid_frame();
    logic prev;
    int   rises, dcnt;
    prev = 1'b0; rises = 0; dcnt = 0;
    @(negedge clk);
    start_a = 1'b1;
    tx_a    = $urandom;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 400 && rises < 12; i++) begin
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
      miso_a = 1'($urandom);
      if (rises < 12) @(negedge clk);
    end
    n_vec++; if (rises !== 12) begin n_err++; $display("FAIL midreset_reach_bit12: got %0d rises want 12", rises); end
    reset_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b1;
    n_vec++; if ({cs_a, sclk_a, busy_a, done_a, mosi_a} !== 5'b10000) begin
      n_err++; $display("FAIL midreset_pins: got cs,sclk,busy,done,mosi=%b want 10000", {cs_a, sclk_a, busy_a, done_a, mosi_a}); end
    n_vec++; if (rx_a !== 32'h0) begin n_err++; $display("FAIL midreset_rx: got %h want 00000000", rx_a); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_a) dcnt++;
    end
    n_vec++; if (dcnt !== 0) begin n_err++; $display("FAIL midreset_no_done: got %0d done pulses want 0", dcnt); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] tx, mw, rxd;
    int rises, dat, dcnt, csb;
    logic bf, bd;
    tx = $urandom;
    run_frame_a(tx, 32'h0F0F_A5A5, 1'b0, 100, mw, rises, dat, dcnt, rxd, csb, bf, bd);
    n_vec++; if (mw !== tx) begin n_err++; $display("FAIL busy_start_mosi: got %h want %h", mw, tx); end
    n_vec++; if (dcnt !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d want 1", dcnt); end
    n_vec++; if (dat !== 65*DA + 1) begin n_err++; $display("FAIL busy_start_done_time: got T0+%0d want T0+%0d", dat, 65*DA + 1); end
  endtask

  task automatic test_random_glitch();
    logic [31:0] tx, sl, mw, rxd;
    int rises, dat, dcnt, csb;
    logic bf, bd;
    for (int f = 0; f < 4; f++) begin
      tx = $urandom;
      sl = $urandom;
      run_frame_a(tx, sl, 1'b1, -1, mw, rises, dat, dcnt, rxd, csb, bf, bd);
      n_vec++; if (mw !== tx) begin n_err++; $display("FAIL rand_mosi[%0d]: got %h want %h", f, mw, tx); end
      n_vec++; if (rxd !== sl) begin n_err++; $display("FAIL rand_rx[%0d]: got %h want %h", f, rxd, sl); end
      n_vec++; if (dat !== 65*DA + 1) begin n_err++; $display("FAIL rand_done_time[%0d]: got %0d want %0d", f, dat, 65*DA + 1); end
    end
  endtask

  task automatic test_pin_timing();
    logic [31:0] tx, mw;
    logic prev, cs_pre, cs_first;
    int rises, run_len, run_min, run_max, runs, cs_rise;
    tx = $urandom;
    @(negedge clk);
    start_b = 1'b1;
    tx_b    = tx;
    cs_pre  = cs_b;
    @(negedge clk);
    start_b = 1'b0;
    tx_b    = $urandom;
    prev = 1'b0; rises = 0; run_len = 0; run_min = 1000; run_max = 0; runs = 0;
    cs_rise = -1; cs_first = cs_b; mw = '0;
    for (int n = 1; n <= 65*DB + GAP + 2; n++) begin
      if (n > 1) @(negedge clk);
      if (sclk_b !== prev) begin
        runs++;
        if (run_len < run_min) run_min = run_len;
        if (run_len > run_max) run_max = run_len;
        run_len = 0;
      end
      run_len++;
      if (sclk_b && !prev) begin
        rises++;
        mw = {mw[30:0], mosi_b};
      end
      prev = sclk_b;
      if (cs_rise < 0 && cs_b) cs_rise = n;
      miso_b = 1'($urandom);
    end
    n_vec++; if (cs_pre !== 1'b1) begin n_err++; $display("FAIL pin_cs_at_t0: got %b want 1", cs_pre); end
    n_vec++; if (cs_first !== 1'b0) begin n_err++; $display("FAIL pin_cs_fall_t1: got %b want 0", cs_first); end
    n_vec++; if (rises !== 32) begin n_err++; $display("FAIL pin_rises: got %0d want 32", rises); end
    n_vec++; if (runs !== 64) begin n_err++; $display("FAIL pin_half_periods: got %0d want 64", runs); end
    n_vec++; if (run_min !== DB || run_max !== DB) begin
      n_err++; $display("FAIL pin_half_len: got min %0d max %0d want %0d", run_min, run_max, DB); end
    n_vec++; if (cs_rise !== 65*DB + 1) begin n_err++; $display("FAIL pin_cs_rise: got T0+%0d want T0+%0d", cs_rise, 65*DB + 1); end
    n_vec++; if (mw !== tx) begin n_err++; $display("FAIL pin_mosi: got %h want %h", mw, tx); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 2*(65*DA + 1 + GAP) + 20;
    logic cs_h[1:N];
    logic busy_h[1:N];
    logic done_h[1:N];
    int d1, d2, cs_run, busy_cnt, idle_at;
    @(negedge clk);
    start_a = 1'b1;
    tx_a    = $urandom;
    for (int n = 1; n <= N; n++) begin
      @(negedge clk);
      cs_h[n] = cs_a; busy_h[n] = busy_a; done_h[n] = done_a;
      miso_a = 1'($urandom);
    end
    start_a = 1'b0;
    d1 = -1; d2 = -1;
    for (int n = 1; n <= N; n++) begin
      if (done_h[n] === 1'b1) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    cs_run = 0; busy_cnt = 0;
    if (d1 > 0) begin
      for (int n = d1; n <= N && cs_h[n] === 1'b1; n++) begin
        cs_run++;
        if (busy_h[n] === 1'b1) busy_cnt++;
      end
    end
    n_vec++; if (d1 !== 65*DA + 1) begin n_err++; $display("FAIL b2b_first_done: got %0d want %0d", d1, 65*DA + 1); end
    n_vec++; if (d2 - d1 !== 65*DA + 1 + (GAP_ON ? GAP : 0)) begin
      n_err++; $display("FAIL b2b_done_spacing: got %0d want %0d", d2 - d1, 65*DA + 1 + (GAP_ON ? GAP : 0)); end
    n_vec++; if (cs_run !== (GAP_ON ? GAP + 1 : 1)) begin
      n_err++; $display("FAIL b2b_cs_high: got %0d cycles want %0d", cs_run, GAP_ON ? GAP + 1 : 1); end
    n_vec++; if (busy_cnt !== (GAP_ON ? GAP : 0)) begin
      n_err++; $display("FAIL b2b_busy_in_gap: got %0d cycles want %0d", busy_cnt, GAP_ON ? GAP : 0); end
    idle_at = -1;
    for (int i = 0; i < 65*DA + GAP + 40 && idle_at < 0; i++) begin
      @(negedge clk);
      if (!busy_a) idle_at = i;
    end
    n_vec++; if (idle_at < 0) begin n_err++; $display("FAIL b2b_return_idle: got busy stuck want idle"); end
  endtask

  initial begin
    reset_a = 1'b0; start_a = 1'b0; tx_a = '0; miso_a = 1'b0;
    reset_b = 1'b0; start_b = 1'b0; tx_b = '0; miso_b = 1'b0;
    test_reset();
    test_single_frame();
    test_reset_mid_frame();
    test_start_while_busy();
    test_random_glitch();
    test_pin_timing();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
